// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - keyed-line Morse receiver decoding letters A..H
module morse_decoder #(
    parameter int DOT_MAX   = 1,
    parameter int GAP_TICKS = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic       key_in,
    output logic       letter_valid,
    output logic       letter_err,
    output logic [2:0] letter_code,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    localparam logic [2:0] DOT_MAX_C = 3'(DOT_MAX);
    localparam logic [3:0] GAP_C     = 4'(GAP_TICKS);

    state_t     state_q, state_d;
    logic [2:0] mark_cnt_q, mark_cnt_d;
    logic [2:0] space_cnt_q, space_cnt_d;
    logic [3:0] sym_q, sym_d;
    logic [2:0] nsym_q, nsym_d;
    logic       ovf_q, ovf_d;

    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic [2:0] code_q, code_d;
    logic       busy_q, busy_d;

    logic [3:0] space_inc;
    logic [3:0] dec;

    // Unused sym slots stay zero, so {nsym, sym} is a complete match key.
    function automatic logic [3:0] decode(input logic [2:0] n, input logic [3:0] s);
        case ({n, s})
            7'b010_0010: decode = 4'b1_000; // A .-
            7'b100_0001: decode = 4'b1_001; // B -...
            7'b100_0101: decode = 4'b1_010; // C -.-.
            7'b011_0001: decode = 4'b1_011; // D -..
            7'b001_0000: decode = 4'b1_100; // E .
            7'b100_0100: decode = 4'b1_101; // F ..-.
            7'b011_0011: decode = 4'b1_110; // G --.
            7'b100_0000: decode = 4'b1_111; // H ....
            default:     decode = 4'b0_000;
        endcase
    endfunction

    assign space_inc = {1'b0, space_cnt_q} + 4'd1;
    assign dec       = decode(nsym_q, sym_q);

    // State and symbol-store registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            mark_cnt_q  <= 3'd0;
            space_cnt_q <= 3'd0;
            sym_q       <= 4'd0;
            nsym_q      <= 3'd0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mark_cnt_q  <= mark_cnt_d;
            space_cnt_q <= space_cnt_d;
            sym_q       <= sym_d;
            nsym_q      <= nsym_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next state plus mark/space timing and symbol accumulation.
    always_comb begin
        state_d     = state_q;
        mark_cnt_d  = mark_cnt_q;
        space_cnt_d = space_cnt_q;
        sym_d       = sym_q;
        nsym_d      = nsym_q;
        ovf_d       = ovf_q;
        case (state_q)
            S_IDLE: begin
                sym_d  = 4'd0;
                nsym_d = 3'd0;
                ovf_d  = 1'b0;
                if (key_in) begin
                    state_d    = S_MARK;
                    mark_cnt_d = 3'd0;
                end
            end
            S_MARK: begin
                if (key_in) begin
                    if (tick && mark_cnt_q != 3'd7) begin
                        mark_cnt_d = mark_cnt_q + 3'd1;
                    end
                end else begin
                    space_cnt_d = 3'd0;
                    if (mark_cnt_q == 3'd0) begin
                        // Mark shorter than one tick: drop it.
                        state_d = (nsym_q == 3'd0) ? S_IDLE : S_SPACE;
                    end else begin
                        state_d = S_SPACE;
                        if (nsym_q < 3'd4) begin
                            sym_d[nsym_q[1:0]] = (mark_cnt_q > DOT_MAX_C);
                            nsym_d             = nsym_q + 3'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            S_SPACE: begin
                if (key_in) begin
                    state_d    = S_MARK;
                    mark_cnt_d = 3'd0;
                end else if (tick) begin
                    space_cnt_d = (space_cnt_q == 3'd7) ? 3'd7 : space_inc[2:0];
                    if (space_inc == GAP_C) begin
                        state_d = S_EMIT;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                sym_d   = 4'd0;
                nsym_d  = 3'd0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // Output next values: result pulse from EMIT, busy from next state.
    always_comb begin
        valid_d = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        busy_d  = (state_d != S_IDLE);
        if (state_q == S_EMIT) begin
            if (ovf_q || !dec[3]) begin
                err_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                code_d  = dec[2:0];
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
        end
    end

    assign letter_valid = valid_q;
    assign letter_err   = err_q;
    assign letter_code  = code_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_morse_decoder.sv
// tb/tb_morse_decoder.sv - scoreboard bench for morse_decoder
module tb_morse_decoder;

    logic       clk;
    logic       resetn;
    logic       tick;
    logic       key_in;
    logic       letter_valid;
    logic       letter_err;
    logic [2:0] letter_code;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // {err, code}: err=1 expects letter_err with code held.
    logic [3:0] exp_q[$];
    logic [2:0] held_code;

    morse_decoder #(.DOT_MAX(1), .GAP_TICKS(3)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .tick         (tick),
        .key_in       (key_in),
        .letter_valid (letter_valid),
        .letter_err   (letter_err),
        .letter_code  (letter_code),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pop one expectation for every result pulse.
    always @(negedge clk) begin
        if (resetn && (letter_valid || letter_err)) begin
            logic [3:0] e;
            checks++;
            if (letter_valid && letter_err) begin
                errors++;
                $display("FAIL both_pulses: valid=%0b err=%0b, required only one", letter_valid, letter_err);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b code=%03b, required no pulse",
                         letter_valid, letter_err, letter_code);
            end else begin
                e = exp_q.pop_front();
                if (letter_err !== e[3] || letter_valid !== !e[3] || letter_code !== e[2:0]) begin
                    errors++;
                    $display("FAIL letter: got valid=%0b err=%0b code=%03b, required valid=%0b err=%0b code=%03b",
                             letter_valid, letter_err, letter_code, !e[3], e[3], e[2:0]);
                end
            end
        end
    end

    task automatic step(input logic k, input logic t);
        key_in = k;
        tick   = t;
        @(posedge clk);
        #1;
    endtask

    task automatic mark(input int n);
        repeat (n + 1) step(1'b1, 1'b1);
    endtask

    task automatic low(input int c);
        repeat (c) step(1'b0, 1'b1);
    endtask

    // s[0] first symbol, 1 = dash; marks are 1 tick (dot) or 3 ticks (dash).
    task automatic send_letter(input logic [3:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            mark(s[i] ? 3 : 1);
            if (i < n - 1) low(2);
        end
        low(6);
    endtask

    task automatic expect_ok(input logic [2:0] code);
        exp_q.push_back({1'b0, code});
        held_code = code;
    endtask

    task automatic expect_err();
        exp_q.push_back({1'b1, held_code});
    endtask

    task automatic check1(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    logic [3:0] pat_s[8];
    int         pat_n[8];

    initial begin
        pat_s = '{4'b0010, 4'b0001, 4'b0101, 4'b0001, 4'b0000, 4'b0100, 4'b0011, 4'b0000};
        pat_n = '{2, 4, 4, 3, 1, 4, 3, 4};
        held_code = 3'd0;
        resetn = 1'b0;
        key_in = 1'b0;
        tick   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("reset_valid", {3'd0, letter_valid}, 4'd0);
        check1("reset_err",   {3'd0, letter_err},   4'd0);
        check1("reset_code",  {1'b0, letter_code},  4'd0);
        check1("reset_busy",  {3'd0, busy},         4'd0);
        resetn = 1'b1;

        // Idle line with ticks: nothing happens.
        low(10);
        check1("idle_busy", {3'd0, busy}, 4'd0);

        // Letter A.
        expect_ok(3'b000);
        send_letter(4'b0010, 2);
        check1("a_busy_back", {3'd0, busy}, 4'd0);

        // All letters back-to-back.
        for (int i = 0; i < 8; i++) begin
            expect_ok(3'(i));
            send_letter(pat_s[i], pat_n[i]);
        end

        // Five dots overflow.
        expect_err();
        for (int i = 0; i < 5; i++) begin
            mark(1);
            if (i < 4) low(2);
        end
        low(6);

        // "--" has no match.
        expect_err();
        send_letter(4'b0011, 2);

        // Glitch between sparse ticks, then E with a tick every 4 cycles.
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check1("glitch_busy", {3'd0, busy}, 4'd0);
        step(1'b0, 1'b1);
        expect_ok(3'b100);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, (i % 4) == 0);
        check1("gated_busy", {3'd0, busy}, 4'd0);

        // Key falls on a tick with mark_cnt=1: still a dot (E).
        expect_ok(3'b100);
        mark(1);
        low(6);

        // Key rises on the tick that would reach the gap: letter continues (A).
        expect_ok(3'b000);
        mark(1);
        low(3);
        mark(3);
        low(6);

        // Build a nonzero held code first so the reset value is observable.
        expect_ok(3'b110);
        send_letter(4'b0011, 3);

        // Async reset mid-SPACE of B.
        mark(3);
        low(2);
        mark(1);
        low(2);
        check1("pre_reset_busy", {3'd0, busy}, 4'd1);
        #2;
        resetn = 1'b0;
        #1;
        check1("arst_valid", {3'd0, letter_valid}, 4'd0);
        check1("arst_err",   {3'd0, letter_err},   4'd0);
        check1("arst_code",  {1'b0, letter_code},  4'd0);
        check1("arst_busy",  {3'd0, busy},         4'd0);
        held_code = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        low(12);
        check1("post_reset_busy", {3'd0, busy}, 4'd0);

        expect_ok(3'b111);
        send_letter(4'b0000, 4);

        low(20);
        check1("scoreboard_empty", 4'(exp_q.size()), 4'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
